// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU for the sort datapath: ADD/SUB/CMP/CAS with
// valid/ready handshakes on both sides and a saturating swap counter.
module alu_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [2:0]       alu_op,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result2,
    output logic             lt,
    output logic             gt,
    output logic             eq,
    output logic             ovf,
    output logic             swapped,
    output logic [CNT_W-1:0] swap_count,
    input  logic             cnt_clear
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_CMP = 3'b010,
        OP_CAS = 3'b011
    } alu_op_e;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_op1_q, s1_op1_d;
    logic [WIDTH-1:0] s1_op2_q, s1_op2_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic             s1_signed_q, s1_signed_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result2_q, result2_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             ovf_q, ovf_d;
    logic             swapped_q, swapped_d;
    logic [CNT_W-1:0] swap_count_q, swap_count_d;

    logic             advance;
    logic             accept;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             a_lt_b;
    logic             a_eq_b;
    logic             a_gt_b;
    logic [WIDTH-1:0] c_result;
    logic [WIDTH-1:0] c_result2;
    logic             c_lt, c_gt, c_eq, c_ovf, c_swapped;

    // Handshake control and stage 1 capture.
    always_comb begin
        advance     = !out_valid_q || out_ready;
        accept      = !s1_valid_q || advance;
        s1_valid_d  = s1_valid_q;
        s1_op1_d    = s1_op1_q;
        s1_op2_d    = s1_op2_q;
        s1_op_d     = s1_op_q;
        s1_signed_d = s1_signed_q;
        if (accept) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op1_d    = op1;
                s1_op2_d    = op2;
                s1_op_d     = alu_op;
                s1_signed_d = signed_mode;
            end
        end
    end

    // Datapath evaluated on the stage 1 registers.
    always_comb begin
        sum_ext   = {1'b0, s1_op1_q} + {1'b0, s1_op2_q};
        diff_ext  = {1'b0, s1_op1_q} - {1'b0, s1_op2_q};
        a_eq_b    = (s1_op1_q == s1_op2_q);
        if (s1_signed_q) begin
            a_lt_b = ($signed(s1_op1_q) < $signed(s1_op2_q));
        end else begin
            a_lt_b = (s1_op1_q < s1_op2_q);
        end
        a_gt_b    = !a_lt_b && !a_eq_b;

        c_result  = '0;
        c_result2 = '0;
        c_lt      = 1'b0;
        c_gt      = 1'b0;
        c_eq      = 1'b0;
        c_ovf     = 1'b0;
        c_swapped = 1'b0;

        case (s1_op_q)
            OP_ADD: begin
                c_result = sum_ext[WIDTH-1:0];
                if (s1_signed_q) begin
                    c_ovf = (s1_op1_q[WIDTH-1] == s1_op2_q[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != s1_op1_q[WIDTH-1]);
                end else begin
                    c_ovf = sum_ext[WIDTH];
                end
            end
            OP_SUB: begin
                c_result = diff_ext[WIDTH-1:0];
                if (s1_signed_q) begin
                    c_ovf = (s1_op1_q[WIDTH-1] != s1_op2_q[WIDTH-1]) &&
                            (diff_ext[WIDTH-1] != s1_op1_q[WIDTH-1]);
                end else begin
                    // Extended subtraction leaves the borrow in the top bit.
                    c_ovf = diff_ext[WIDTH];
                end
            end
            OP_CMP: begin
                c_lt = a_lt_b;
                c_gt = a_gt_b;
                c_eq = a_eq_b;
            end
            OP_CAS: begin
                c_lt      = a_lt_b;
                c_gt      = a_gt_b;
                c_eq      = a_eq_b;
                c_swapped = a_gt_b;
                c_result  = a_gt_b ? s1_op2_q : s1_op1_q;
                c_result2 = a_gt_b ? s1_op1_q : s1_op2_q;
            end
            default: begin
                c_result = '0;
            end
        endcase
    end

    // Stage 2 load and swap counter.
    always_comb begin
        out_valid_d  = out_valid_q;
        result_d     = result_q;
        result2_d    = result2_q;
        lt_d         = lt_q;
        gt_d         = gt_q;
        eq_d         = eq_q;
        ovf_d        = ovf_q;
        swapped_d    = swapped_q;
        swap_count_d = swap_count_q;

        if (advance) begin
            out_valid_d = s1_valid_q;
            result_d    = c_result;
            result2_d   = c_result2;
            lt_d        = c_lt;
            gt_d        = c_gt;
            eq_d        = c_eq;
            ovf_d       = c_ovf;
            swapped_d   = c_swapped;
        end

        if (cnt_clear) begin
            swap_count_d = '0;
        end else if (out_valid_q && out_ready && swapped_q && (swap_count_q != '1)) begin
            swap_count_d = swap_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_op1_q     <= '0;
            s1_op2_q     <= '0;
            s1_op_q      <= '0;
            s1_signed_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            result2_q    <= '0;
            lt_q         <= 1'b0;
            gt_q         <= 1'b0;
            eq_q         <= 1'b0;
            ovf_q        <= 1'b0;
            swapped_q    <= 1'b0;
            swap_count_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op1_q     <= s1_op1_d;
            s1_op2_q     <= s1_op2_d;
            s1_op_q      <= s1_op_d;
            s1_signed_q  <= s1_signed_d;
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            result2_q    <= result2_d;
            lt_q         <= lt_d;
            gt_q         <= gt_d;
            eq_q         <= eq_d;
            ovf_q        <= ovf_d;
            swapped_q    <= swapped_d;
            swap_count_q <= swap_count_d;
        end
    end

    assign in_ready   = accept;
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign result2    = result2_q;
    assign lt         = lt_q;
    assign gt         = gt_q;
    assign eq         = eq_q;
    assign ovf        = ovf_q;
    assign swapped    = swapped_q;
    assign swap_count = swap_count_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=16, CNT_W=2) with a queue-based
// reference model checked every cycle plus literal per-test expectations.
module tb_alu_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [2:0]  alu_op;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [15:0] result2;
    logic        lt, gt, eq, ovf, swapped;
    logic [1:0]  swap_count;
    logic        cnt_clear;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] res2;
        logic        lt;
        logic        gt;
        logic        eq;
        logic        ovf;
        logic        sw;
    } beat_t;

    beat_t exp_q[$];
    int    model_cnt = 0;

    alu_pipe #(.WIDTH(16), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op1        (op1),
        .op2        (op2),
        .alu_op     (alu_op),
        .signed_mode(signed_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .result2    (result2),
        .lt         (lt),
        .gt         (gt),
        .eq         (eq),
        .ovf        (ovf),
        .swapped    (swapped),
        .swap_count (swap_count),
        .cnt_clear  (cnt_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic longint key(input logic [15:0] v, input logic sm);
        if (sm) return longint'($signed(v));
        return longint'(v);
    endfunction

    // Reference behaviour from plain integer arithmetic.
    function automatic beat_t model(input logic [15:0] a, input logic [15:0] b,
                                    input logic [2:0] op, input logic sm);
        beat_t  r;
        longint s, ks, ka, kb;
        r  = '0;
        ka = key(a, sm);
        kb = key(b, sm);
        case (op)
            3'd0: begin
                s     = longint'(a) + longint'(b);
                r.res = 16'(s);
                ks    = key(a, 1'b1) + key(b, 1'b1);
                r.ovf = sm ? (ks > 32767 || ks < -32768) : (s > 65535);
            end
            3'd1: begin
                s     = longint'(a) - longint'(b);
                r.res = 16'(s);
                ks    = key(a, 1'b1) - key(b, 1'b1);
                r.ovf = sm ? (ks > 32767 || ks < -32768) : (a < b);
            end
            3'd2, 3'd3: begin
                r.lt = (ka < kb);
                r.gt = (ka > kb);
                r.eq = (ka == kb);
                if (op == 3'd3) begin
                    r.res  = (ka <= kb) ? a : b;
                    r.res2 = (ka <= kb) ? b : a;
                    r.sw   = (ka > kb);
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        beat_t act;
        beat_t front;
        logic  deliver_sw;
        if (rst) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            deliver_sw = 1'b0;
            act = {result, result2, lt, gt, eq, ovf, swapped};
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    front = exp_q[0];
                    check("model_beat", act, front);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        deliver_sw = front.sw;
                    end
                end
            end
            check("model_swap_count", swap_count, model_cnt);
            if (cnt_clear) model_cnt = 0;
            else if (deliver_sw && model_cnt < 3) model_cnt++;
            if (in_valid && in_ready) exp_q.push_back(model(op1, op2, alu_op, signed_mode));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, input logic sm);
        op1 = a; op2 = b; alu_op = op; signed_mode = sm; in_valid = 1'b1;
    endtask

    task automatic single(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, input logic sm, input logic [15:0] er,
                          input logic [15:0] er2, input logic [4:0] fl);
        drive(a, b, op, sm);
        tick();
        in_valid = 1'b0;
        tick();
        check({name, "_valid"}, out_valid, 1);
        check({name, "_result"}, result, er);
        check({name, "_result2"}, result2, er2);
        check({name, "_flags"}, {lt, gt, eq, ovf, swapped}, fl);
        tick();
    endtask

    initial begin
        beat_t pin;
        rst = 1'b1; in_valid = 1'b0; op1 = '0; op2 = '0; alu_op = '0;
        signed_mode = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;

        pin = model(16'hFFFF, 16'h0001, 3'd0, 1'b0);
        check("pin_model_add", pin, {16'h0000, 16'h0000, 5'b00010});
        pin = model(16'h0009, 16'h0003, 3'd3, 1'b0);
        check("pin_model_cas", pin, {16'h0003, 16'h0009, 5'b01001});
        pin = model(16'h8000, 16'h0001, 3'd1, 1'b1);
        check("pin_model_sub", pin, {16'h7FFF, 16'h0000, 5'b00010});

        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_swap_count", swap_count, 0);
        check("rst_fields", {result, result2, lt, gt, eq, ovf, swapped}, 0);
        rst = 1'b0;
        tick();

        single("add_u", 16'hFFFF, 16'h0001, 3'd0, 1'b0, 16'h0000, 16'h0, 5'b00010);
        single("add_s", 16'h7FFF, 16'h0001, 3'd0, 1'b1, 16'h8000, 16'h0, 5'b00010);
        single("sub_u", 16'd5,    16'd7,    3'd1, 1'b0, 16'hFFFE, 16'h0, 5'b00010);
        single("sub_s", 16'h8000, 16'h0001, 3'd1, 1'b1, 16'h7FFF, 16'h0, 5'b00010);
        single("cmp_u", 16'hFFFF, 16'h0001, 3'd2, 1'b0, 16'h0000, 16'h0, 5'b01000);
        single("cmp_s", 16'hFFFF, 16'h0001, 3'd2, 1'b1, 16'h0000, 16'h0, 5'b10000);
        single("cmp_eq", 16'd42,  16'd42,   3'd2, 1'b0, 16'h0000, 16'h0, 5'b00100);
        single("rsvd",  16'hFFFF, 16'h0001, 3'd5, 1'b1, 16'h0000, 16'h0, 5'b00000);

        // CAS stream at one beat per cycle.
        drive(16'd9, 16'd3, 3'd3, 1'b0);
        tick();
        drive(16'd3, 16'd9, 3'd3, 1'b0);
        tick();
        check("cas0", {out_valid, result, result2, swapped}, {1'b1, 16'd3, 16'd9, 1'b1});
        drive(16'd4, 16'd4, 3'd3, 1'b0);
        tick();
        in_valid = 1'b0;
        check("cas1", {out_valid, result, result2, swapped}, {1'b1, 16'd3, 16'd9, 1'b0});
        tick();
        check("cas2", {out_valid, result, result2, swapped}, {1'b1, 16'd4, 16'd4, 1'b0});
        tick();
        check("cas_swap_count", swap_count, 1);
        tick();

        // Back-pressure: three beats offered with out_ready low.
        out_ready = 1'b0;
        drive(16'd1, 16'd2, 3'd3, 1'b0);
        tick();
        drive(16'd10, 16'd20, 3'd0, 1'b0);
        tick();
        drive(16'd30, 16'd5, 3'd1, 1'b0);
        check("bp_in_ready0", in_ready, 0);
        check("bp_hold0", {out_valid, result, result2, lt}, {1'b1, 16'd1, 16'd2, 1'b1});
        tick();
        check("bp_in_ready1", in_ready, 0);
        check("bp_hold1", {out_valid, result, result2, lt}, {1'b1, 16'd1, 16'd2, 1'b1});
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp_next", {out_valid, result}, {1'b1, 16'd30});
        tick();
        check("bp_last", {out_valid, result}, {1'b1, 16'd25});
        tick();
        check("bp_empty", out_valid, 0);

        // Saturation with CNT_W=2.
        repeat (5) begin
            drive(16'd8, 16'd2, 3'd3, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check("sat_count", swap_count, 3);

        drive(16'd8, 16'd2, 3'd3, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        check("clr_beat_visible", {out_valid, swapped}, 2'b11);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        check("clr_wins", swap_count, 0);
        tick();

        // Reset with two beats in flight.
        drive(16'd1, 16'd2, 3'd0, 1'b0);
        tick();
        drive(16'd3, 16'd4, 3'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("inflight_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post_rst_valid", out_valid, 0);
        check("post_rst_ready", in_ready, 1);
        repeat (3) begin
            tick();
            check("post_rst_idle", out_valid, 0);
        end
        single("after_rst", 16'h1234, 16'h0001, 3'd0, 1'b0, 16'h1235, 16'h0, 5'b00000);

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined successor to the combinational 16-bit ALU in the sorting datapath. It adds SUB and compare-and-swap (CAS) operations, signed/unsigned compare, overflow reporting and valid/ready handshakes on both sides. It also keeps a saturating count of swapping CAS operations, so the bubble-sort controller can detect a pass with no swaps. It sits between the sort FSM's operand fetch and its memory write-back.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits (≥ 2)
- CNT_W, 16, width of swap_count

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat offered
- in_ready  out  1  input beat accepted this cycle when in_valid && in_ready
- op1  in  WIDTH  first operand
- op2  in  WIDTH  second operand
- alu_op  in  3  000 ADD, 001 SUB, 010 CMP, 011 CAS, 1xx reserved
- signed_mode  in  1  1 = operands are two's complement for compare and overflow
- out_valid  out  1  result beat held
- out_ready  in  1  downstream accepts result when out_valid && out_ready
- result  out  WIDTH  primary result
- result2  out  WIDTH  secondary result (CAS max), else 0
- lt, gt, eq  out  1 each  op1 vs op2 compare flags
- ovf  out  1  ADD/SUB overflow
- swapped  out  1  CAS beat exchanged its operands
- swap_count  out  CNT_W  saturating count of swapping CAS beats delivered
- cnt_clear  in  1  synchronous clear of swap_count

## Operation
- ADD: result = (op1 + op2) mod 2^WIDTH.
  - ovf = carry-out when signed_mode = 0; signed overflow (operand signs equal, result sign differs) when 1.
- SUB: result = (op1 − op2) mod 2^WIDTH.
  - ovf = borrow (op1 < op2 unsigned) when signed_mode = 0; signed overflow (operand signs differ, result sign ≠ op1 sign) when 1.
- CMP: result = 0, result2 = 0. Exactly one of lt/gt/eq is 1, using signed or unsigned compare per signed_mode.
- CAS: flags as CMP. result = min(op1, op2), result2 = max(op1, op2), swapped = gt.
  - eq yields result = result2 = op1, swapped = 0.
- Flags not listed for an op are 0. ADD/SUB drive lt/gt/eq/swapped = 0 and result2 = 0. CMP/CAS drive ovf = 0.
- Reserved ops still produce an output beat with every output field 0.
- signed_mode is sampled with its beat; it does not affect ADD/SUB result bits.
- swap_count increments by 1 on each output handshake of a CAS beat with swapped = 1, and saturates at 2^CNT_W − 1.
- cnt_clear sets swap_count to 0 next edge. If clear coincides with an increment, clear wins (count = 0).

## Timing
- Stage 1 registers op1, op2, alu_op and signed_mode (s1_valid). Stage 2 registers all computed outputs (out_valid). No combinational input-to-output data path.
- Pipeline stages:
  - advance = !out_valid || out_ready
  - stage 2 loads from stage 1 when advance
  - in_ready = !s1_valid || advance (combinational from out_ready)
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+1, when no stall occurs. Throughput is 1 beat/cycle with out_ready held high.
- Stall: while out_valid && !out_ready, every output holds stable. Stage 1 holds, and in_ready = 0 if stage 1 is full. No beat is dropped or duplicated.
- Bubbles: an empty stage 1 moving into stage 2 clears out_valid. Output data fields are don't-care while out_valid = 0.
- Reset (rst = 1 at an edge):
  - s1_valid, out_valid, result, result2, lt, gt, eq, ovf, swapped and swap_count all go to 0.
  - in_ready reads 1 the cycle after reset.
  - Reset mid-operation discards in-flight beats. No partial beat is emitted afterwards.
- Beats leave in acceptance order.

## Test plan
- WIDTH=16, unsigned ADD 0xFFFF + 0x0001 → two cycles later result = 0x0000, ovf = 1. Signed ADD 0x7FFF + 0x0001 → result = 0x8000, ovf = 1.
- SUB 5 − 7: unsigned → result = 0xFFFE, ovf = 1. Signed 0x8000 − 0x0001 → result = 0x7FFF, ovf = 1.
- CMP 0xFFFF vs 0x0001: unsigned → gt = 1. Signed → lt = 1. Equal operands 42, 42 → eq = 1 only.
- CAS stream (9,3), (3,9), (4,4) at one beat/cycle with out_ready = 1 → (3,9, swapped 1), (3,9, 0), (4,4, 0) on consecutive cycles; swap_count = 1.
- Back-pressure: hold out_ready = 0 for 3 cycles with 3 beats offered → in_ready drops after 2 accepted, outputs stay stable. Release → both beats emerge in order with no loss.
- CNT_W=2: deliver 5 swapping CAS beats → swap_count saturates at 3. cnt_clear coincident with a swapping beat → 0. Assert rst with 2 beats in flight → out_valid = 0 next cycle and thereafter until a new beat is fed.
